// File: rtl/tx_msgctrl_bank.sv
// tx_msgctrl_bank: bank of NBUF CPU-written transmit message buffers with a
// single IDLE/REQ/BUSY controller that hands the lowest pending buffer to
// the transmit controller and writes the outcome back into the buffer.
//
// Buffer word: [15] treq, [14] tind, [13] terr, [12:10] retry count,
// [9:0] CPU payload (never modified here).
//
// Optional feature: define TXBANK_RETRY_EN to retry a failed buffer up to
// MAXRETRY times before flagging terr; without it, an error flags terr
// immediately and leaves the retry-count field as the CPU wrote it.
//
// Handshake: tx_req is held high in REQ with tx_sel stable until tx_ack
// (one-cycle pulse) is seen; tx_done (one-cycle pulse, outcome on tsucf)
// is honoured only in BUSY. Pulses arriving in any other state are ignored.
//
// fsm_state_o exposes the controller state: 0 = IDLE, 1 = REQ, 2 = BUSY.
module tx_msgctrl_bank #(
  parameter int NBUF     = 4,
  parameter int MAXRETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBUF-1:0]      cpu_we,
  input  logic [15:0]          reginp,
  input  logic                 tx_ack,
  input  logic                 tx_done,
  input  logic                 tsucf,
  output logic [16*NBUF-1:0]   regout,
  output logic                 tx_req,
  output logic [2:0]           tx_sel,
  output logic                 busy,
  output logic [1:0]           fsm_state_o
);

`ifdef TXBANK_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [15:0] buf_q [NBUF];
  logic [15:0] buf_d [NBUF];

  logic [NBUF-1:0] treq;
  logic            any_req;
  logic [2:0]      low_idx;
  logic [15:0]     sel_word;
  logic [15:0]     upd_word;
  logic [2:0]      cnt;
  logic            complete;

  // Pending flags and fixed-priority pick of the lowest pending buffer
  always_comb begin
    treq    = '0;
    low_idx = 3'd0;
    for (int i = 0; i < NBUF; i++) treq[i] = buf_q[i][15];
    any_req = |treq;
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (treq[i]) low_idx = 3'(i);
    end
  end

  // Word of the currently selected buffer
  always_comb begin
    sel_word = 16'h0000;
    for (int i = 0; i < NBUF; i++) begin
      if (sel_q == 3'(i)) sel_word = buf_q[i];
    end
  end

  // Outcome write-back value for the selected buffer
  always_comb begin
    upd_word = sel_word;
    cnt      = sel_word[12:10];
    if (tsucf) begin
      upd_word[15]    = 1'b0;
      upd_word[14]    = 1'b1;
      upd_word[13]    = 1'b0;
      upd_word[12:10] = 3'd0;
    end else if (RETRY_EN && (int'(cnt) < MAXRETRY)) begin
      // Keep treq set so the buffer is arbitrated again; count saturates
      upd_word[12:10] = (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
    end else begin
      upd_word[15] = 1'b0;
      upd_word[13] = 1'b1;
    end
  end

  assign complete = (state_q == S_BUSY) && tx_done;

  // Buffer next-state: controller write-back, CPU write has the last word
  always_comb begin
    for (int i = 0; i < NBUF; i++) begin
      buf_d[i] = buf_q[i];
      if (complete && (sel_q == 3'(i))) buf_d[i] = upd_word;
      if (cpu_we[i]) buf_d[i] = reginp;
    end
  end

  // Controller next-state and selection
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          sel_d   = low_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (tx_ack)            state_d = S_BUSY;
        else if (!sel_word[15]) state_d = S_IDLE;
      end
      S_BUSY: begin
        if (tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, selection and buffer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      for (int i = 0; i < NBUF; i++) buf_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      for (int i = 0; i < NBUF; i++) buf_q[i] <= buf_d[i];
    end
  end

  // Moore-decoded outputs and buffer packing
  always_comb begin
    tx_req      = (state_q == S_REQ);
    busy        = (state_q == S_BUSY);
    tx_sel      = sel_q;
    fsm_state_o = state_q;
    regout      = '0;
    for (int i = 0; i < NBUF; i++) regout[16*i +: 16] = buf_q[i];
  end

endmodule

// File: doc/tx_msgctrl_bank.md
TX_MSGCTRL_BANK -- requirements
Module: tx_msgctrl_bank

Interface
REQ-001 Parameter NBUF, default 4, number of transmit buffers, legal range 1..8.
REQ-002 Parameter MAXRETRY, default 3, retries after a failed attempt, legal range 0..7.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 cpu_we  input  NBUF  CPU write strobe, one bit per buffer.
REQ-006 reginp  input  16  CPU write data, shared by all buffers.
REQ-007 tx_ack  input  1  controller has accepted the request; one-cycle pulse.
REQ-008 tx_done  input  1  transmission finished; one-cycle pulse.
REQ-009 tsucf  input  1  outcome qualified by tx_done: 1 = success, 0 = error.
REQ-010 regout  output  16*NBUF  buffer registers; buffer i occupies bits [16i+15:16i].
REQ-011 tx_req  output  1  request to the controller.
REQ-012 tx_sel  output  3  index of the selected buffer; valid while tx_req or busy is 1.
REQ-013 busy  output  1  high in state BUSY.

Function
REQ-014 Buffer layout: bit15 treq, bit14 tind (success), bit13 terr (retries exhausted), bits12:10 retry count, bits9:0 CPU data that the block SHALL NOT modify.
REQ-015 If cpu_we[i] is 1, regout[i] SHALL take reginp at the next edge, overriding any controller update to buffer i in the same cycle.
REQ-016 FSM states: IDLE, REQ, BUSY; all outputs SHALL be registered or Moore-decoded.
REQ-017 In IDLE, if any treq is 1, the FSM SHALL latch the lowest pending index into tx_sel and go to REQ at the next edge.
- A CPU write setting treq at edge k SHALL therefore give tx_req=1 after edge k+1.
REQ-018 In REQ, tx_req SHALL be 1 and tx_sel SHALL stay stable; tx_ack SHALL move the FSM to BUSY.
REQ-019 In REQ, if the selected treq reads 0 and tx_ack is 0, the FSM SHALL return to IDLE (abort before acceptance).
- If tx_ack and treq=0 occur in the same cycle, tx_ack wins.
REQ-020 In BUSY, tx_done with tsucf=1 SHALL, for the selected buffer, clear treq, set tind, clear terr and clear the retry count; the FSM goes to IDLE.
REQ-021 In BUSY, tx_done with tsucf=0 SHALL handle the failure per the Configuration section; the FSM goes to IDLE.
REQ-022 tx_ack outside REQ and tx_done outside BUSY SHALL be ignored.
REQ-023 The retry count SHALL saturate at 7 and never wrap.
REQ-024 A selected buffer that is re-requested after IDLE is arbitrated again from index 0; fixed priority, no fairness.

Reset
REQ-025 With rst=0 at an edge: all regout bits 0, FSM in IDLE, tx_req=0, busy=0, tx_sel=0.
REQ-026 Reset SHALL take precedence over cpu_we, tx_ack and tx_done, including while in BUSY; the in-flight result is discarded.

Configuration
REQ-027 Macro TXBANK_RETRY_EN controls retry behaviour.
REQ-028 With TXBANK_RETRY_EN defined, on an error with retry count < MAXRETRY, the block SHALL increment the count and keep treq=1; otherwise it SHALL clear treq and set terr.
REQ-029 Without TXBANK_RETRY_EN, on an error the block SHALL clear treq and set terr immediately; bits12:10 SHALL stay as the CPU wrote them.

Verification
REQ-030 Reset, then write 0x8000 to buffer 2 -> tx_req=1 and tx_sel=2 two edges after the write; tx_ack -> busy=1; tx_done with tsucf=1 -> regout[2]=0x4000, state IDLE.
REQ-031 Buffers 1 and 3 requested in the same cycle -> buffer 1 is served first; after it completes, buffer 3 is selected.
REQ-032 With RETRY_EN and MAXRETRY=2, three error completions on buffer 0 -> count goes 1, then 2, then treq=0 and terr=1 (regout[0]=0x2800).
REQ-033 In REQ, CPU writes 0x0000 to the selected buffer before tx_ack -> tx_req drops and the FSM returns to IDLE.
REQ-034 CPU write and tx_done to the same buffer in the same cycle -> regout equals the written value; rst=0 during BUSY -> all outputs return to 0.
